// File: rtl/niosii_tick_accumulator.sv
// -----------------------------------------------------------------------------
// niosii_tick_accumulator
//
// Purpose
//   Avalon-MM slave that takes the level irq of an upstream interval timer as
//   tick_in. It counts rising edges of that tick and compares the count against
//   a programmable COMPARE value. A match raises MATCH, and irq is driven when
//   CONTROL.ITO is set. Unserviced matches are tallied in PEND, which saturates.
//   OVR flags a match that arrives while MATCH is still set, so an RTOS can
//   detect lost ticks.
//
// Parameters
//   COUNT_W  tick counter width, 1..16, zero-extended on readdata
//   PEND_W   pending-match counter width, 1..16, saturates at all-ones
//
// Ports
//   clk         system clock (single domain)
//   reset       synchronous, active-high reset
//   address     word address: 0 STATUS, 1 CONTROL, 2 COUNT, 3 COMPARE,
//               4 PEND, 5 TSTAMP_L, 6 TSTAMP_H, 7 unmapped
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data
//   tick_in     level irq from the upstream timer, same clock
//   irq         MATCH && CONTROL.ITO
//
// Register map
//   STATUS  (0) read  {13'b0, RUN, OVR, MATCH}; any write clears MATCH/OVR
//   CONTROL (1) read  {13'b0, AUTO, RUN, ITO}; write bit3 = CLR strobe
//   COUNT   (2) r/w   tick count
//   COMPARE (3) r/w   match value, 0 disables matching
//   PEND    (4) read  pending matches; any write clears it
//
// Optional feature (macro NIOSII_TICK_TIMESTAMP_EN)
//   Adds a 32-bit free-running cycle counter. It is latched into tstamp on
//   every counted edge. Address 5 reads tstamp[15:0]. A write to address 5
//   freezes tstamp[31:16] into a shadow register, and address 6 reads that
//   shadow. Without the macro, addresses 5/6 read 0 and writes there are
//   ignored.
// -----------------------------------------------------------------------------
module niosii_tick_accumulator #(
  parameter int COUNT_W = 16,
  parameter int PEND_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        tick_in,
  output logic        irq
);

  // Bus handshake: this slave has no wait states. A write is accepted on
  // every cycle where chipselect is high and write_n is low. Read data is
  // always the registered value of the selected register as it stood one
  // cycle earlier, so the read latency is fixed at 1 and no valid/ready pair
  // is needed.

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_COUNT   = 3'd2;
  localparam logic [2:0] ADDR_COMPARE = 3'd3;
  localparam logic [2:0] ADDR_PEND    = 3'd4;
`ifdef NIOSII_TICK_TIMESTAMP_EN
  localparam logic [2:0] ADDR_TS_L    = 3'd5;
  localparam logic [2:0] ADDR_TS_H    = 3'd6;
`endif

  // Register state
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] compare_q;
  logic [PEND_W-1:0]  pend_q;
  logic               match_q;
  logic               ovr_q;
  logic               ito_q;
  logic               run_q;
  logic               auto_q;
  logic               tick_d;

  // Decoded strobes
  logic wr;
  logic wr_status;
  logic wr_control;
  logic wr_count;
  logic wr_compare;
  logic wr_pend;
  logic clr_strobe;

  // Counting datapath
  logic               tick_edge;
  logic               load_count;
  logic               count_edge;
  logic               match_hit;
  logic [COUNT_W-1:0] count_inc;
  logic [COUNT_W-1:0] count_next;
  logic [PEND_W-1:0]  pend_base;
  logic [PEND_W-1:0]  pend_next;
  logic               match_next;
  logic               ovr_next;

  // Read path
  logic [15:0] count_ext;
  logic [15:0] compare_ext;
  logic [15:0] pend_ext;
  logic [15:0] rd_mux;

  assign wr         = chipselect && !write_n;
  assign wr_status  = wr && (address == ADDR_STATUS);
  assign wr_control = wr && (address == ADDR_CONTROL);
  assign wr_count   = wr && (address == ADDR_COUNT);
  assign wr_compare = wr && (address == ADDR_COMPARE);
  assign wr_pend    = wr && (address == ADDR_PEND);
  assign clr_strobe = wr_control && writedata[3];

  assign tick_edge  = tick_in && !tick_d;

  // A COUNT write or CLR owns the counter for that cycle. Any coincident
  // edge is dropped, not deferred.
  assign load_count = wr_count || clr_strobe;
  assign count_edge = tick_edge && run_q && !load_count;

  always_comb begin
    count_inc = count_q + COUNT_W'(1);
    // compare_q is the registered value, so a same-cycle COMPARE write only
    // affects later edges.
    match_hit = count_edge && (compare_q != '0) && (count_inc == compare_q);

    count_next = count_q;
    if (load_count) begin
      count_next = clr_strobe ? '0 : writedata[COUNT_W-1:0];
    end else if (count_edge) begin
      count_next = (match_hit && auto_q) ? '0 : count_inc;
    end

    // A PEND clear and a new match in one cycle leave pend at 1.
    pend_base = wr_pend ? '0 : pend_q;
    pend_next = pend_base;
    if (match_hit && (pend_base != '1)) begin
      pend_next = pend_base + PEND_W'(1);
    end

    // A new match wins over a STATUS clear. OVR looks at MATCH as it was
    // before the clear, so a match that lands on top of a pending one is
    // never lost.
    match_next = wr_status ? 1'b0 : match_q;
    ovr_next   = wr_status ? 1'b0 : ovr_q;
    if (match_hit) begin
      match_next = 1'b1;
      if (match_q) begin
        ovr_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= '0;
      match_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ito_q     <= 1'b0;
      run_q     <= 1'b0;
      auto_q    <= 1'b0;
      tick_d    <= 1'b0;
    end else begin
      // tick_d follows tick_in even while stopped. A level that is already
      // high when RUN is set therefore does not count.
      tick_d  <= tick_in;
      count_q <= count_next;
      pend_q  <= pend_next;
      match_q <= match_next;
      ovr_q   <= ovr_next;
      if (wr_compare) begin
        compare_q <= writedata[COUNT_W-1:0];
      end
      if (wr_control) begin
        ito_q  <= writedata[0];
        run_q  <= writedata[1];
        auto_q <= writedata[2];
      end
    end
  end

  // Both operands are registered, so irq cannot glitch.
  assign irq = match_q && ito_q;

`ifdef NIOSII_TICK_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] tstamp_q;
  logic [15:0] tstamp_h_shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q         <= '0;
      tstamp_q        <= '0;
      tstamp_h_shadow <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (count_edge) begin
        tstamp_q <= cycle_q;
      end
      // Reading the low half and then the high half is only coherent if the
      // high half is frozen in between. Software writes address 5 to do that.
      if (wr && (address == ADDR_TS_L)) begin
        tstamp_h_shadow <= tstamp_q[31:16];
      end
    end
  end
`endif

  always_comb begin
    count_ext                = '0;
    count_ext[COUNT_W-1:0]   = count_q;
    compare_ext              = '0;
    compare_ext[COUNT_W-1:0] = compare_q;
    pend_ext                 = '0;
    pend_ext[PEND_W-1:0]     = pend_q;

    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = {13'b0, run_q, ovr_q, match_q};
      ADDR_CONTROL: rd_mux = {13'b0, auto_q, run_q, ito_q};
      ADDR_COUNT:   rd_mux = count_ext;
      ADDR_COMPARE: rd_mux = compare_ext;
      ADDR_PEND:    rd_mux = pend_ext;
`ifdef NIOSII_TICK_TIMESTAMP_EN
      ADDR_TS_L:    rd_mux = tstamp_q[15:0];
      ADDR_TS_H:    rd_mux = tstamp_h_shadow;
`endif
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
